exec_forward_datapath: RTL and testbench

- Execute/memory/writeback datapath that consumes the dependency-check block's decode and forwarding outputs: op_dec, imm, imm_sel, mux_sel_A, mux_sel_B, RW_dm, mem_en_ex, mem_rw_ex and mem_mux_sel_dm.
- Contains a 32x32 register file, the operand forwarding muxes, the ALU, the EX/DM/WB pipeline registers and a word-addressed data memory.
- Writes results back to the register file.

---
 rtl/exec_forward_datapath.sv | 184 ++++++++++++++++++
 tb/tb_exec_forward_datapath.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_forward_datapath.sv
// Execute / memory / writeback datapath with operand forwarding, 32x32 regfile and word-addressed data memory.
// Optional build macro OVF_FLAG_EN enables the sticky signed-overflow flag on ovf.
module exec_forward_datapath #(
  parameter int DM_DEPTH = 64,
  parameter int DM_AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic [5:0]  op_dec,
  input  logic [15:0] imm,
  input  logic        imm_sel,
  input  logic [1:0]  mux_sel_A,
  input  logic [1:0]  mux_sel_B,
  input  logic        mem_en_ex,
  input  logic        mem_rw_ex,
  input  logic        mem_mux_sel_dm,
  input  logic [4:0]  RW_dm,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_we,
  output logic        dm_oob,
  output logic        ovf
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic [4:0]  ra_q, ra_d, rb_q, rb_d;
  logic [31:0] ex_q, ex_d, st_q, st_d;
  logic [31:0] alu_dm_q, alu_dm_d, rd_q, rd_d;
  logic [31:0] wb_q, wb_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic        wb_we_q, wb_we_d;
  logic        dm_oob_q, dm_oob_d;
  logic        mem_live_q, mem_live_d;

  logic [31:0] regfile_q [32];
  logic [31:0] mem [DM_DEPTH];

  logic [31:0] rf_a, rf_b, fwd_a, fwd_b, opnd_a, opnd_b;
  logic [31:0] sum, diff, alu_res, dm_q;
  logic [2:0]  alu_op;
  logic        is_ls;
  logic [DM_AW-1:0] mem_addr;

  always_comb begin
    ra_d = src_a;
    rb_d = src_b;
  end

  always_comb begin
    rf_a = (ra_q == 5'd0) ? 32'd0 : regfile_q[ra_q];
    rf_b = (rb_q == 5'd0) ? 32'd0 : regfile_q[rb_q];
    fwd_a = rf_a;
    case (mux_sel_A)
      2'b01:   fwd_a = ex_q;
      2'b10:   fwd_a = dm_q;
      2'b11:   fwd_a = wb_q;
      default: fwd_a = rf_a;
    endcase
    fwd_b = rf_b;
    case (mux_sel_B)
      2'b01:   fwd_b = ex_q;
      2'b10:   fwd_b = dm_q;
      2'b11:   fwd_b = wb_q;
      default: fwd_b = rf_b;
    endcase
    opnd_a = fwd_a;
    opnd_b = imm_sel ? {{16{imm[15]}}, imm} : fwd_b;
  end

  // Loads and stores always compute base + offset regardless of the low opcode bits.
  always_comb begin
    is_ls   = (op_dec[5:3] == 3'b010);
    alu_op  = is_ls ? ALU_ADD : op_dec[2:0];
    sum     = opnd_a + opnd_b;
    diff    = opnd_a - opnd_b;
    alu_res = sum;
    case (alu_op)
      ALU_ADD: alu_res = sum;
      ALU_SUB: alu_res = diff;
      ALU_AND: alu_res = opnd_a & opnd_b;
      ALU_OR:  alu_res = opnd_a | opnd_b;
      ALU_XOR: alu_res = opnd_a ^ opnd_b;
      ALU_SLT: alu_res = {31'd0, ($signed(opnd_a) < $signed(opnd_b))};
      ALU_SLL: alu_res = opnd_a << opnd_b[4:0];
      ALU_SRL: alu_res = opnd_a >> opnd_b[4:0];
      default: alu_res = sum;
    endcase
    ex_d = alu_res;
    st_d = fwd_b;
  end

  always_comb begin
    mem_addr   = ex_q[DM_AW+1:2];
    alu_dm_d   = ex_q;
    rd_d       = (mem_en_ex && !mem_rw_ex) ? mem[mem_addr] : rd_q;
    dm_oob_d   = dm_oob_q | (mem_en_ex && (ex_q[31:DM_AW+2] != '0));
    mem_live_d = 1'b1;
  end

  always_comb begin
    dm_q      = mem_mux_sel_dm ? rd_q : alu_dm_q;
    wb_d      = dm_q;
    wb_addr_d = RW_dm;
    wb_we_d   = (RW_dm != 5'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_q       <= '0;
      rb_q       <= '0;
      ex_q       <= '0;
      st_q       <= '0;
      alu_dm_q   <= '0;
      rd_q       <= '0;
      wb_q       <= '0;
      wb_addr_q  <= '0;
      wb_we_q    <= 1'b0;
      dm_oob_q   <= 1'b0;
      mem_live_q <= 1'b0;
    end else begin
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      ex_q       <= ex_d;
      st_q       <= st_d;
      alu_dm_q   <= alu_dm_d;
      rd_q       <= rd_d;
      wb_q       <= wb_d;
      wb_addr_q  <= wb_addr_d;
      wb_we_q    <= wb_we_d;
      dm_oob_q   <= dm_oob_d;
      mem_live_q <= mem_live_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regfile_q[i] <= '0;
    end else if (wb_we_d) begin
      regfile_q[RW_dm] <= dm_q;
    end
  end

  // mem_live_q stays low while reset is held, so no store lands during reset.
  always_ff @(posedge clk) begin
    if (mem_live_q && mem_en_ex && mem_rw_ex) mem[mem_addr] <= st_q;
  end

`ifdef OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic add_ovf, sub_ovf;

  always_comb begin
    add_ovf = (opnd_a[31] == opnd_b[31]) && (sum[31] != opnd_a[31]);
    sub_ovf = (opnd_a[31] != opnd_b[31]) && (diff[31] != opnd_a[31]);
    ovf_d   = ovf_q | (!is_ls && (((alu_op == ALU_ADD) && add_ovf) ||
                                  ((alu_op == ALU_SUB) && sub_ovf)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign wb_data = wb_q;
  assign wb_addr = wb_addr_q;
  assign wb_we   = wb_we_q;
  assign dm_oob  = dm_oob_q;

endmodule

// File: tb/tb_exec_forward_datapath.sv
// Directed self-checking bench for exec_forward_datapath; each instruction's fields are staged by cycle.
module tb_exec_forward_datapath;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_SLL = 6'b000110;
  localparam logic [5:0] OP_SRL = 6'b000111;
  localparam logic [5:0] OP_LW  = 6'b010010;
  localparam logic [5:0] OP_SW  = 6'b010001;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  sa;
    logic [1:0]  fa;
    logic [4:0]  sb;
    logic [1:0]  fb;
    logic        isel;
    logic [15:0] imm;
    logic        men;
    logic        mrw;
    logic        mmux;
    logic [4:0]  rw;
    logic        chk;
    logic [31:0] exp;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  src_a = '0, src_b = '0;
  logic [5:0]  op_dec = '0;
  logic [15:0] imm = '0;
  logic        imm_sel = 1'b0;
  logic [1:0]  mux_sel_A = '0, mux_sel_B = '0;
  logic        mem_en_ex = 1'b0, mem_rw_ex = 1'b0, mem_mux_sel_dm = 1'b0;
  logic [4:0]  RW_dm = '0;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_we, dm_oob, ovf;

  int n_checks = 0;
  int n_fail = 0;
  ins_t p1 = '0, p2 = '0, p3 = '0;

  exec_forward_datapath #(.DM_DEPTH(64), .DM_AW(6)) dut (
    .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b), .op_dec(op_dec),
    .imm(imm), .imm_sel(imm_sel), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
    .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .RW_dm(RW_dm), .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
    .dm_oob(dm_oob), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(input logic [5:0] op, input logic [4:0] sa, input logic [1:0] fa,
                              input logic [4:0] sb, input logic [1:0] fb, input logic isel,
                              input logic [15:0] im, input logic men, input logic mrw,
                              input logic mmux, input logic [4:0] rw, input logic [31:0] exp);
    ins_t r;
    r.op = op; r.sa = sa; r.fa = fa; r.sb = sb; r.fb = fb; r.isel = isel; r.imm = im;
    r.men = men; r.mrw = mrw; r.mmux = mmux; r.rw = rw; r.chk = 1'b1; r.exp = exp;
    return r;
  endfunction

  function automatic ins_t alu_i(input logic [5:0] op, input logic [4:0] sa, input logic [1:0] fa,
                                 input logic [15:0] im, input logic [4:0] rw, input logic [31:0] exp);
    return mk(op, sa, fa, 5'd0, 2'b00, 1'b1, im, 1'b0, 1'b0, 1'b0, rw, exp);
  endfunction

  function automatic ins_t alu_r(input logic [5:0] op, input logic [4:0] sa, input logic [1:0] fa,
                                 input logic [4:0] sb, input logic [1:0] fb, input logic [4:0] rw,
                                 input logic [31:0] exp);
    return mk(op, sa, fa, sb, fb, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, rw, exp);
  endfunction

  // Drive each in-flight instruction's fields in its own stage, advance one clock, report what wrote back.
  task automatic step(input ins_t ins, output ins_t done);
    src_a = ins.sa; src_b = ins.sb;
    op_dec = p1.op; imm = p1.imm; imm_sel = p1.isel; mux_sel_A = p1.fa; mux_sel_B = p1.fb;
    mem_en_ex = p2.men; mem_rw_ex = p2.mrw;
    mem_mux_sel_dm = p3.mmux; RW_dm = p3.rw;
    @(posedge clk); #1;
    done = p3; p3 = p2; p2 = p1; p1 = ins;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (wb_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_wb_data got %h want 0", wb_data); end
    n_checks++; if (wb_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_wb_addr got %0d want 0", wb_addr); end
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wb_we got %b want 0", wb_we); end
    n_checks++; if (dm_oob !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dm_oob got %b want 0", dm_oob); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_imm();
    ins_t q[$];
    ins_t d;
    q.push_back(alu_i(OP_ADD, 5'd0, 2'b00, 16'd5, 5'd1, 32'd5));
    q.push_back(alu_i(OP_ADD, 5'd0, 2'b00, 16'd7, 5'd2, 32'd7));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL add_imm_data R%0d got %h want %h", d.rw, wb_data, d.exp); end
        n_checks++; if (wb_we !== (d.rw != 5'd0)) begin n_fail++; $display("[TB] FAIL add_imm_we R%0d got %b", d.rw, wb_we); end
        n_checks++; if (wb_addr !== d.rw) begin n_fail++; $display("[TB] FAIL add_imm_addr got %0d want %0d", wb_addr, d.rw); end
      end
    end
  endtask

  task automatic test_forward();
    ins_t q[$];
    ins_t d;
    q.push_back(alu_r(OP_ADD, 5'd1, 2'b00, 5'd2, 2'b00, 5'd3, 32'd12));
    q.push_back(alu_r(OP_ADD, 5'd3, 2'b01, 5'd3, 2'b01, 5'd4, 32'd24));
    q.push_back(alu_r(OP_ADD, 5'd1, 2'b00, 5'd2, 2'b00, 5'd3, 32'd12));
    q.push_back('0);
    q.push_back(alu_r(OP_ADD, 5'd3, 2'b10, 5'd3, 2'b10, 5'd4, 32'd24));
    q.push_back(alu_r(OP_ADD, 5'd1, 2'b00, 5'd2, 2'b00, 5'd3, 32'd12));
    q.push_back('0);
    q.push_back('0);
    q.push_back(alu_r(OP_ADD, 5'd3, 2'b11, 5'd3, 2'b11, 5'd4, 32'd24));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL forward_data idx%0d R%0d got %h want %h", i, d.rw, wb_data, d.exp); end
        n_checks++; if (wb_addr !== d.rw) begin n_fail++; $display("[TB] FAIL forward_addr got %0d want %0d", wb_addr, d.rw); end
      end
    end
  endtask

  task automatic test_alu_ops();
    ins_t q[$];
    ins_t d;
    q.push_back(alu_i(OP_ADD, 5'd0, 2'b00, 16'hFFF0, 5'd8, 32'hFFFF_FFF0));
    repeat (3) q.push_back('0);
    q.push_back(alu_i(OP_SUB, 5'd8, 2'b00, 16'h0001, 5'd0, 32'hFFFF_FFEF));
    q.push_back(alu_i(OP_AND, 5'd8, 2'b00, 16'h00FF, 5'd0, 32'h0000_00F0));
    q.push_back(alu_i(OP_OR,  5'd8, 2'b00, 16'h000F, 5'd0, 32'hFFFF_FFFF));
    q.push_back(alu_i(OP_XOR, 5'd8, 2'b00, 16'hFFFF, 5'd0, 32'h0000_000F));
    q.push_back(alu_i(OP_SLT, 5'd8, 2'b00, 16'h0005, 5'd0, 32'd1));
    q.push_back(alu_i(OP_SLT, 5'd4, 2'b00, 16'h0005, 5'd0, 32'd0));
    q.push_back(alu_i(OP_SLL, 5'd8, 2'b00, 16'h0004, 5'd0, 32'hFFFF_FF00));
    q.push_back(alu_i(OP_SLL, 5'd8, 2'b00, 16'h0024, 5'd0, 32'hFFFF_FF00));
    q.push_back(alu_i(OP_SRL, 5'd8, 2'b00, 16'h0004, 5'd0, 32'h0FFF_FFFF));
    q.push_back(alu_r(OP_SUB, 5'd4, 2'b00, 5'd3, 2'b00, 5'd16, 32'd12));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL alu_op%0d idx%0d got %h want %h", d.op, i, wb_data, d.exp); end
        n_checks++; if (wb_we !== (d.rw != 5'd0)) begin n_fail++; $display("[TB] FAIL alu_we idx%0d got %b", i, wb_we); end
      end
    end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_no_ovf got %b want 0", ovf); end
  endtask

  task automatic test_load_store();
    ins_t q[$];
    ins_t d;
    q.push_back(mk(OP_SW, 5'd0, 2'b00, 5'd4, 2'b00, 1'b1, 16'd8,  1'b1, 1'b1, 1'b0, 5'd0, 32'd8));
    q.push_back('0);
    q.push_back(mk(OP_LW, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 16'd8,  1'b1, 1'b0, 1'b1, 5'd5, 32'd24));
    q.push_back(mk(OP_SW, 5'd0, 2'b00, 5'd3, 2'b00, 1'b1, 16'd12, 1'b1, 1'b1, 1'b0, 5'd0, 32'd12));
    q.push_back(mk(OP_LW, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 16'd12, 1'b1, 1'b0, 1'b1, 5'd6, 32'd12));
    q.push_back(mk(OP_SW, 5'd0, 2'b00, 5'd3, 2'b00, 1'b1, 16'd16, 1'b1, 1'b1, 1'b0, 5'd0, 32'd16));
    q.push_back(mk(OP_SW, 5'd0, 2'b00, 5'd4, 2'b00, 1'b1, 16'd16, 1'b1, 1'b1, 1'b0, 5'd0, 32'd16));
    q.push_back(mk(OP_LW, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 16'd17, 1'b1, 1'b0, 1'b1, 5'd7, 32'd24));
    repeat (3) q.push_back('0);
    q.push_back(alu_r(OP_ADD, 5'd5, 2'b00, 5'd6, 2'b00, 5'd9, 32'd36));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL ldst_data idx%0d got %h want %h", i, wb_data, d.exp); end
        n_checks++; if (wb_we !== (d.rw != 5'd0)) begin n_fail++; $display("[TB] FAIL ldst_we idx%0d got %b", i, wb_we); end
      end
    end
  endtask

  task automatic test_r0();
    ins_t q[$];
    ins_t d;
    q.push_back(alu_i(OP_ADD, 5'd0, 2'b00, 16'd9, 5'd0, 32'd9));
    repeat (3) q.push_back('0);
    q.push_back(alu_r(OP_ADD, 5'd0, 2'b00, 5'd0, 2'b00, 5'd10, 32'd0));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL r0_data idx%0d got %h want %h", i, wb_data, d.exp); end
        n_checks++; if (wb_we !== (d.rw != 5'd0)) begin n_fail++; $display("[TB] FAIL r0_we idx%0d got %b", i, wb_we); end
        n_checks++; if (wb_addr !== d.rw) begin n_fail++; $display("[TB] FAIL r0_addr idx%0d got %0d want %0d", i, wb_addr, d.rw); end
      end
    end
  endtask

  task automatic test_oob();
    ins_t d;
    step(mk(OP_LW, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 16'h00FC, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0FC), d);
    repeat (3) step('0, d);
    n_checks++; if (dm_oob !== 1'b0) begin n_fail++; $display("[TB] FAIL oob_top_word got %b want 0", dm_oob); end
    step(mk(OP_LW, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1000), d);
    repeat (3) step('0, d);
    n_checks++; if (wb_data !== 32'h1000) begin n_fail++; $display("[TB] FAIL oob_addr got %h want 00001000", wb_data); end
    n_checks++; if (dm_oob !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_set got %b want 1", dm_oob); end
    repeat (10) step('0, d);
    n_checks++; if (dm_oob !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_sticky got %b want 1", dm_oob); end
  endtask

  task automatic test_mid_reset();
    ins_t q[$];
    ins_t d;
    step(alu_i(OP_ADD, 5'd0, 2'b00, 16'd77, 5'd11, 32'd77), d);
    step('0, d);
    reset = 1'b0;
    #1;
    n_checks++; if (wb_data !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_wb_data got %h want 0", wb_data); end
    n_checks++; if (wb_addr !== 5'd0) begin n_fail++; $display("[TB] FAIL midrst_wb_addr got %0d want 0", wb_addr); end
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_wb_we got %b want 0", wb_we); end
    n_checks++; if (dm_oob !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_dm_oob got %b want 0", dm_oob); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ovf got %b want 0", ovf); end
    p1 = '0; p2 = '0; p3 = '0;
    src_a = '0; src_b = '0; op_dec = '0; imm = '0; imm_sel = 1'b0; mux_sel_A = '0; mux_sel_B = '0;
    mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel_dm = 1'b0; RW_dm = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin
      step('0, d);
      n_checks++; if (wb_we !== 1'b0 || wb_data !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_discard we=%b data=%h want 0/0", wb_we, wb_data); end
    end
    q.push_back(alu_r(OP_ADD, 5'd4, 2'b00, 5'd11, 2'b00, 5'd12, 32'd0));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL midrst_regfile got %h want %h", wb_data, d.exp); end
      end
    end
  endtask

  task automatic test_ovf();
    ins_t q[$];
    ins_t d;
    logic exp_ovf;
`ifdef OVF_FLAG_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    q.push_back(alu_i(OP_ADD, 5'd0, 2'b00, 16'hFFFF, 5'd13, 32'hFFFF_FFFF));
    q.push_back(alu_i(OP_SRL, 5'd13, 2'b01, 16'h0001, 5'd14, 32'h7FFF_FFFF));
    q.push_back(mk(OP_LW, 5'd14, 2'b01, 5'd0, 2'b00, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 5'd0, 32'h8000_0000));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL ovf_setup idx%0d got %h want %h", i, wb_data, d.exp); end
      end
    end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_ls_excluded got %b want 0", ovf); end
    q.delete();
    q.push_back(alu_i(OP_ADD, 5'd14, 2'b00, 16'h0001, 5'd15, 32'h8000_0000));
    repeat (3) q.push_back('0);
    foreach (q[i]) begin
      step(q[i], d);
      if (d.chk) begin
        n_checks++; if (wb_data !== d.exp) begin n_fail++; $display("[TB] FAIL ovf_add_result got %h want %h", wb_data, d.exp); end
      end
    end
    n_checks++; if (ovf !== exp_ovf) begin n_fail++; $display("[TB] FAIL ovf_flag got %b want %b", ovf, exp_ovf); end
    repeat (4) step('0, d);
    n_checks++; if (ovf !== exp_ovf) begin n_fail++; $display("[TB] FAIL ovf_sticky got %b want %b", ovf, exp_ovf); end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_forward();
    test_alu_ops();
    test_load_store();
    test_r0();
    test_oob();
    test_mid_reset();
    test_ovf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
